// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the multicycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_NOT  = 5'd2;
  localparam logic [4:0] OP_SLL  = 5'd3;
  localparam logic [4:0] OP_SRL  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SLTU = 5'd7;
  localparam logic [4:0] OP_BEQ  = 5'd8;
  localparam logic [4:0] OP_BNE  = 5'd9;
  localparam logic [4:0] OP_BGT  = 5'd10;
  localparam logic [4:0] OP_BGE  = 5'd11;
  localparam logic [4:0] OP_BLT  = 5'd12;
  localparam logic [4:0] OP_BLE  = 5'd13;
  localparam logic [4:0] OP_JMP  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_SRA  = 5'd17;
  // First code of the illegal range (18..31).
  localparam logic [4:0] OP_ILL  = 5'd18;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo hold {partial product, multiplier} or {remainder, quotient/dividend}.
// nxt_hi/nxt_lo show the value after the current iteration so the caller can
// capture the final answer on the same edge the last iteration retires.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] nxt_hi
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi, lo, opb;
  logic             div_q, running;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum, trial, diff;

  assign last = running && (cnt == CW'(WIDTH - 1));

  // One iteration step: add-and-shift for multiply, shift-compare-subtract for divide.
  // A zero divisor always "fits", so the quotient fills with ones and the
  // dividend shifts whole into the remainder.
  always_comb begin
    sum   = {1'b0, hi} + {1'b0, opb};
    trial = {hi, lo[WIDTH-1]};
    diff  = trial - {1'b0, opb};
    if (div_q) begin
      if (trial >= {1'b0, opb}) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = trial[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      {nxt_hi, nxt_lo} = {sum, lo[WIDTH-1:1]};
    end else begin
      {nxt_hi, nxt_lo} = {1'b0, hi, lo[WIDTH-1:1]};
    end
  end

  // Operand capture on load, then exactly WIDTH iterations.
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      opb     <= '0;
      div_q   <= 1'b0;
    end else if (load) begin
      running <= 1'b1;
      cnt     <= '0;
      hi      <= '0;
      lo      <= a;
      opb     <= b;
      div_q   <= is_div;
    end else if (running) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + CW'(1);
      if (last) running <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ops finish in one cycle, MUL/DIV iterate WIDTH cycles.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUCnt,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);
  state_t           state;
  logic [WIDTH-1:0] alu_res, md_lo, md_hi;
  logic             alu_zero, md_load, md_last;

  assign busy    = (state != S_IDLE);
  assign md_load = (state == S_IDLE) && start && (ALUCnt == OP_MUL || ALUCnt == OP_DIV);

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .is_div (ALUCnt == OP_DIV),
    .a      (input1),
    .b      (input2),
    .last   (md_last),
    .nxt_lo (md_lo),
    .nxt_hi (md_hi)
  );

  // Single-cycle datapath; branch codes report their outcome on zero with result 0.
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b1;
    case (ALUCnt)
      OP_ADD:  alu_res = input1 + input2;
      OP_SUB:  alu_res = input1 - input2;
      OP_NOT:  alu_res = ~input1;
      OP_SLL:  alu_res = input1 << shamt;
      OP_SRL:  alu_res = input1 >> shamt;
      OP_AND:  alu_res = input1 & input2;
      OP_OR:   alu_res = input1 | input2;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      OP_SRA:  alu_res = WIDTH'($signed(input1) >>> shamt);
      default: alu_res = '0;
    endcase
    case (ALUCnt)
      OP_BEQ:  alu_zero = (input1 == input2);
      OP_BNE:  alu_zero = (input1 != input2);
      OP_BGT:  alu_zero = (input1 >  input2);
      OP_BGE:  alu_zero = (input1 >= input2);
      OP_BLT:  alu_zero = (input1 <  input2);
      OP_BLE:  alu_zero = (input1 <= input2);
      OP_JMP:  alu_zero = 1'b1;
      default: alu_zero = (ALUCnt >= OP_ILL) ? 1'b1 : (alu_res == '0);
    endcase
  end

  // Control FSM with registered outputs; flags are refreshed at every acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_by_zero <= (ALUCnt == OP_DIV) && (input2 == '0);
            illegal_op  <= (ALUCnt >= OP_ILL);
            if (ALUCnt == OP_MUL) begin
              state <= S_MUL;
            end else if (ALUCnt == OP_DIV) begin
              state <= S_DIV;
            end else begin
              state     <= S_DONE;
              done      <= 1'b1;
              result    <= alu_res;
              result_hi <= '0;
              zero      <= alu_zero;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (md_last) begin
            state     <= S_DONE;
            done      <= 1'b1;
            result    <= md_lo;
            result_hi <= md_hi;
            zero      <= (md_lo == '0);
          end
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
